// File: rtl/instruction_memory_responder.sv
// Block-wide instruction memory with a fixed-latency read handshake and word preload port.
// A read is accepted from IDLE and returns the whole 128-bit block LATENCY edges later.
module instruction_memory_responder #(
  parameter int LATENCY      = 4,
  parameter int DEPTH_BLOCKS = 64,
  localparam int AW          = $clog2(DEPTH_BLOCKS)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          MEM_READ,
  input  logic [27:0]   MEM_ADDRESS,
  output logic [127:0]  MEM_READDATA,
  output logic          MEM_BUSYWAIT,
  input  logic          LOAD_EN,
  input  logic [AW+1:0] LOAD_ADDR,
  input  logic [31:0]   LOAD_DATA
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [7:0]      count;
  logic [AW-1:0]   block_q;
  logic            capture;
  logic [3:0][31:0] mem [DEPTH_BLOCKS];

  // Upper address bits alias onto the stored blocks.
  logic addr_unused;
  assign addr_unused = ^MEM_ADDRESS[27:AW];

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_next   = state;
    MEM_BUSYWAIT = 1'b0;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        MEM_BUSYWAIT = MEM_READ;
        if (MEM_READ) state_next = BUSY;
      end
      BUSY: begin
        MEM_BUSYWAIT = 1'b1;
        if (!MEM_READ) begin
          state_next = IDLE;
        end else if (count == 8'd0) begin
          state_next = DONE;
          capture    = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Reset must mask the combinational IDLE path as well.
    if (!RESET) MEM_BUSYWAIT = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= IDLE;
      count        <= 8'd0;
      block_q      <= '0;
      MEM_READDATA <= 128'h0;
    end else begin
      state <= state_next;
      if (state == IDLE && MEM_READ) begin
        block_q <= MEM_ADDRESS[AW-1:0];
        count   <= 8'(LATENCY - 1);
      end else if (state == BUSY && count != 8'd0) begin
        count <= count - 8'd1;
      end
      // A same-edge preload is not yet visible here, so capture returns pre-write data.
      if (capture) MEM_READDATA <= mem[block_q];
    end
  end

  // NOTE: the array has no reset so contents survive RESET and map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (LOAD_EN) mem[LOAD_ADDR[AW+1:2]][LOAD_ADDR[1:0]] <= LOAD_DATA;
  end

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Self-checking bench for instruction_memory_responder: vector table, hand-written
// corner sequences and randomized reads/preloads against a transaction-level model.
module tb_instruction_memory_responder;

  localparam int LATENCY = 4;
  localparam int DEPTH   = 64;
  localparam int AW      = 6;

  logic          CLK;
  logic          RESET;
  logic          MEM_READ;
  logic [27:0]   MEM_ADDRESS;
  logic [127:0]  MEM_READDATA;
  logic          MEM_BUSYWAIT;
  logic          LOAD_EN;
  logic [AW+1:0] LOAD_ADDR;
  logic [31:0]   LOAD_DATA;

  instruction_memory_responder #(
    .LATENCY      (LATENCY),
    .DEPTH_BLOCKS (DEPTH)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .LOAD_EN      (LOAD_EN),
    .LOAD_ADDR    (LOAD_ADDR),
    .LOAD_DATA    (LOAD_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: array contents plus the last block a completed read returned.
  logic [3:0][31:0] ref_mem [DEPTH];
  logic [127:0]     last_data;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    string        name;
    logic [27:0]  addr;
    int           abort_at;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] pat_word(input int b, input int w);
    if (b == 0) return {4{8'(8'h11 * (w + 1))}};
    return 32'hB000_0000 | 32'(b << 8) | 32'(w);
  endfunction

  function automatic logic [127:0] pat_block(input int b);
    return {pat_word(b, 3), pat_word(b, 2), pat_word(b, 1), pat_word(b, 0)};
  endfunction

  // One clock edge with an optional preload; the model applies the write after the edge.
  task automatic cycle(input logic en, input logic [AW+1:0] a, input logic [31:0] d);
    LOAD_EN   = en;
    LOAD_ADDR = a;
    LOAD_DATA = d;
    @(posedge CLK);
    if (en) ref_mem[a[AW+1:2]][a[1:0]] = d;
    #1;
    LOAD_EN = 1'b0;
  endtask

  task automatic cycle_rand(input bit rand_load);
    if (rand_load && $urandom_range(0, 2) == 0)
      cycle(1'b1, (AW+2)'($urandom), $urandom);
    else
      cycle(1'b0, '0, 32'h0);
  endtask

  // Full read transaction. abort_at in 1..LATENCY drops MEM_READ before that post-acceptance
  // edge; 0 completes. hold leaves MEM_READ high after DONE for the caller.
  task automatic do_read(input logic [27:0] addr, input int abort_at, input bit rand_load,
                         input bit hold);
    logic [127:0] exp_data;
    int           blk;
    blk         = int'(addr[AW-1:0]);
    exp_data    = last_data;
    MEM_ADDRESS = addr;
    MEM_READ    = 1'b1;
    #1;
    check("busy_rise", 128'(MEM_BUSYWAIT), 128'd1);
    cycle_rand(rand_load);
    for (int e = 1; e <= LATENCY; e++) begin
      MEM_ADDRESS = 28'($urandom);
      if (e == abort_at) MEM_READ = 1'b0;
      check("busy_hold", 128'(MEM_BUSYWAIT), 128'd1);
      if (e == LATENCY) exp_data = ref_mem[blk];
      cycle_rand(rand_load);
      if (e == abort_at) begin
        check("abort_busy", 128'(MEM_BUSYWAIT), 128'd0);
        check("abort_data", MEM_READDATA, last_data);
        return;
      end
    end
    check("done_busy", 128'(MEM_BUSYWAIT), 128'd0);
    check("done_data", MEM_READDATA, exp_data);
    last_data = exp_data;
    if (!hold) begin
      MEM_READ = 1'b0;
      cycle_rand(rand_load);
      check("after_done_busy", 128'(MEM_BUSYWAIT), 128'd0);
      check("after_done_data", MEM_READDATA, last_data);
    end
  endtask

  initial begin
    vecs[0] = '{"blk0",       28'h0,       0,       128'h44444444_33333333_22222222_11111111};
    vecs[1] = '{"alias_0x40", 28'h40,      0,       128'h44444444_33333333_22222222_11111111};
    vecs[2] = '{"blk5",       28'h5,       0,       pat_block(5)};
    vecs[3] = '{"blk63",      28'h3F,      0,       pat_block(63)};
    vecs[4] = '{"alias_top",  28'hFFFFFFF, 0,       pat_block(63)};
    vecs[5] = '{"abort_2",    28'h2,       2,       pat_block(63)};
    vecs[6] = '{"abort_last", 28'h9,       LATENCY, pat_block(63)};
    vecs[7] = '{"alias_0x41", 28'h41,      0,       pat_block(1)};

    RESET       = 1'b1;
    MEM_READ    = 1'b1;
    MEM_ADDRESS = 28'h0;
    LOAD_EN     = 1'b0;
    LOAD_ADDR   = '0;
    LOAD_DATA   = 32'h0;
    last_data   = 128'h0;
    #1 RESET = 1'b0;
    #2;
    check("reset_busy", 128'(MEM_BUSYWAIT), 128'd0);
    check("reset_data", MEM_READDATA, 128'h0);
    MEM_READ = 1'b0;
    #4 RESET = 1'b1;

    for (int b = 0; b < DEPTH; b++)
      for (int w = 0; w < 4; w++)
        cycle(1'b1, (AW+2)'(b * 4 + w), pat_word(b, w));

    for (int i = 0; i < 8; i++) begin
      do_read(vecs[i].addr, vecs[i].abort_at, 1'b0, 1'b0);
      check(vecs[i].name, MEM_READDATA, vecs[i].exp);
    end

    // Reset in the middle of BUSY, then a fresh read of block 1.
    MEM_ADDRESS = 28'h3;
    MEM_READ    = 1'b1;
    cycle(1'b0, '0, 32'h0);
    cycle(1'b0, '0, 32'h0);
    cycle(1'b0, '0, 32'h0);
    RESET = 1'b0;
    #1;
    check("midbusy_reset_busy", 128'(MEM_BUSYWAIT), 128'd0);
    check("midbusy_reset_data", MEM_READDATA, 128'h0);
    last_data = 128'h0;
    MEM_READ  = 1'b0;
    #1 RESET = 1'b1;
    do_read(28'h1, 0, 1'b0, 1'b0);
    check("post_reset_blk1", MEM_READDATA, pat_block(1));

    // MEM_READ held through DONE with the address moved to block 2.
    do_read(28'h5, 0, 1'b0, 1'b1);
    MEM_ADDRESS = 28'h2;
    cycle(1'b0, '0, 32'h0);
    check("held_rerise_busy", 128'(MEM_BUSYWAIT), 128'd1);
    check("held_data_kept", MEM_READDATA, pat_block(5));
    do_read(28'h2, 0, 1'b0, 1'b0);
    check("held_blk2", MEM_READDATA, pat_block(2));

    // Preload on the capture edge of the same block returns the old contents.
    MEM_ADDRESS = 28'h7;
    MEM_READ    = 1'b1;
    for (int e = 0; e < LATENCY; e++) cycle(1'b0, '0, 32'h0);
    cycle(1'b1, (AW+2)'(7 * 4), 32'hDEADBEEF);
    check("same_edge_old", MEM_READDATA, pat_block(7));
    MEM_READ = 1'b0;
    cycle(1'b0, '0, 32'h0);
    last_data = pat_block(7);
    do_read(28'h7, 0, 1'b0, 1'b0);
    check("same_edge_new", MEM_READDATA, {pat_word(7, 3), pat_word(7, 2), pat_word(7, 1), 32'hDEADBEEF});

    for (int t = 0; t < 60; t++) begin
      int ab;
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, LATENCY)) : 0;
      do_read(28'($urandom), ab, 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
